// File: rtl/mmss_updown_timer_pkg.sv
// mmss_updown_timer_pkg: BCD MM:SS layout, digit limits and clamp helper
package mmss_updown_timer_pkg;

    localparam int READING_W = 16;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } mmss_t;

    function automatic logic [3:0] dclamp(input logic [3:0] d, input logic [3:0] lim);
        return d > lim ? lim : d;
    endfunction

endpackage

// File: rtl/lim_updown_digit.sv
// lim_updown_digit: one limited BCD digit stepping up or down with carry/borrow out
module lim_updown_digit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] lim,
    input  logic         ci,
    input  logic         dir,
    output logic [W-1:0] next,
    output logic         co
);

    assign co   = ci && (dir ? a == '0 : a >= lim);
    assign next = !ci ? a : co ? (dir ? lim : '0) : (dir ? a - W'(1) : a + W'(1));

endmodule

// File: rtl/mmss_updown_timer.sv
// mmss_updown_timer: BCD MM:SS stopwatch/countdown with preset load, lap capture, tick and done
module mmss_updown_timer
    import mmss_updown_timer_pkg::*;
#(
    parameter int CLK_FREQ    = 100000000,
    parameter int MAX_MINUTES = 59,
    parameter bit WRAP        = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_regs,
    input  logic                 count_enabled,
    input  logic                 count_down,
    input  logic                 load,
    input  logic [READING_W-1:0] load_value,
    input  logic                 lap_capture,
    output logic [READING_W-1:0] time_reading,
    output logic [READING_W-1:0] lap_reading,
    output logic                 tick,
    output logic                 done
);

    localparam int CNT_W = $clog2(CLK_FREQ);
    localparam logic [3:0] TENS_LIM = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] ONES_TOP = 4'(MAX_MINUTES % 10);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    mmss_t time_q, time_d, lap_q, lap_d, ld, raw;
    logic done_q, done_d, tick_q, tick_d;
    logic [3:0] n_so, n_st, n_mo, n_mt, mo_lim;
    logic c0, c1, c2, c3, step, hold, run;
    mmss_t stepped;

    // minute-ones limit follows the minute-tens value the digit will sit under after the step
    assign mo_lim = (count_down ? time_q.min_tens == 4'd0 : time_q.min_tens == TENS_LIM) ? ONES_TOP : DIGIT_MAX;

    lim_updown_digit u_so (.a(time_q.sec_ones), .lim(DIGIT_MAX),    .ci(1'b1), .dir(count_down), .next(n_so), .co(c0));
    lim_updown_digit u_st (.a(time_q.sec_tens), .lim(SEC_TENS_MAX), .ci(c0),   .dir(count_down), .next(n_st), .co(c1));
    lim_updown_digit u_mo (.a(time_q.min_ones), .lim(mo_lim),       .ci(c1),   .dir(count_down), .next(n_mo), .co(c2));
    lim_updown_digit u_mt (.a(time_q.min_tens), .lim(TENS_LIM),     .ci(c2),   .dir(count_down), .next(n_mt), .co(c3));

    assign stepped = '{n_mt, n_mo, n_st, n_so};
    assign run     = count_enabled && !done_q;
    assign step    = run && cnt_q == CNT_W'(CLK_FREQ - 1);
    // chain overflow means MAX:59 going up or 00:00 going down; only up-with-wrap may pass through
    assign hold    = c3 && (count_down || !WRAP);

    // clamp each loaded digit; minutes beyond the top collapse to the maximum minute
    always_comb begin
        raw = mmss_t'(load_value);
        ld.min_tens = dclamp(raw.min_tens, TENS_LIM);
        ld.min_ones = raw.min_tens > TENS_LIM ? ONES_TOP
                    : dclamp(raw.min_ones, ld.min_tens == TENS_LIM ? ONES_TOP : DIGIT_MAX);
        ld.sec_tens = dclamp(raw.sec_tens, SEC_TENS_MAX);
        ld.sec_ones = dclamp(raw.sec_ones, DIGIT_MAX);
    end

    // next state with priority init_regs > load > step; lap capture sees the pre-edge value
    always_comb begin
        cnt_d  = (init_regs || load || step) ? '0 : run ? cnt_q + CNT_W'(1) : cnt_q;
        time_d = init_regs ? '0 : load ? ld : (step && !hold) ? stepped : time_q;
        done_d = (init_regs || load) ? 1'b0 : done_q || (step && (hold || (count_down && stepped == '0)));
        tick_d = !init_regs && !load && step && !hold;
        lap_d  = init_regs ? '0 : lap_capture ? time_q : lap_q;
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            time_q <= '0;
            lap_q  <= '0;
            done_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            time_q <= time_d;
            lap_q  <= lap_d;
            done_q <= done_d;
            tick_q <= tick_d;
        end
    end

    assign time_reading = time_q;
    assign lap_reading  = lap_q;
    assign tick         = tick_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mmss_updown_timer.sv
// tb_mmss_updown_timer: directed checks of the MM:SS timer with CLK_FREQ=4, WRAP=1 and WRAP=0 instances
module tb_mmss_updown_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_regs = 1'b0, count_enabled = 1'b0, count_down = 1'b0, load = 1'b0, lap_capture = 1'b0;
    logic [15:0] load_value = '0;
    logic [15:0] t1, l1, t0, l0;
    logic tk1, d1, tk0, d0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mmss_updown_timer #(.CLK_FREQ(4), .MAX_MINUTES(59), .WRAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .init_regs(init_regs), .count_enabled(count_enabled),
        .count_down(count_down), .load(load), .load_value(load_value), .lap_capture(lap_capture),
        .time_reading(t1), .lap_reading(l1), .tick(tk1), .done(d1)
    );

    mmss_updown_timer #(.CLK_FREQ(4), .MAX_MINUTES(59), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .init_regs(init_regs), .count_enabled(count_enabled),
        .count_down(count_down), .load(load), .load_value(load_value), .lap_capture(lap_capture),
        .time_reading(t0), .lap_reading(l0), .tick(tk0), .done(d0)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_value = v;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        cyc(2);
        check("rst_time", t1, 16'h0000);
        check("rst_done", {15'd0, d1}, 16'd0);
        rst_n = 1'b1;
        count_enabled = 1'b1;
        cyc(4);
        check("first_step", t1, 16'h0001);
        check("first_tick", {15'd0, tk1}, 16'd1);
        cyc(1);
        check("tick_one_cycle", {15'd0, tk1}, 16'd0);
        lap_capture = 1'b1;
        cyc(1);
        lap_capture = 1'b0;
        check("lap_plain", l1, 16'h0001);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_time", t1, 16'h0000);
        check("async_rst_lap", l1, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(4);
        check("restart_step", t1, 16'h0001);
        check("restart_tick", {15'd0, tk1}, 16'd1);

        do_load(16'h0959);
        check("load_0959", t1, 16'h0959);
        cyc(4);
        check("carry_1000", t1, 16'h1000);
        do_load(16'h5959);
        cyc(4);
        check("wrap_time", t1, 16'h0000);
        check("wrap_done", {15'd0, d1}, 16'd0);
        check("wrap_tick", {15'd0, tk1}, 16'd1);
        check("sat_time", t0, 16'h5959);
        check("sat_done", {15'd0, d0}, 16'd1);
        check("sat_tick", {15'd0, tk0}, 16'd0);
        cyc(4);
        check("sat_frozen", t0, 16'h5959);

        count_down = 1'b1;
        do_load(16'h0100);
        check("load_clears_done", {15'd0, d0}, 16'd0);
        cyc(4);
        check("down_0059", t1, 16'h0059);
        cyc(4);
        check("down_0058", t1, 16'h0058);
        do_load(16'h0001);
        cyc(4);
        check("land_zero_time", t1, 16'h0000);
        check("land_zero_tick", {15'd0, tk1}, 16'd1);
        check("land_zero_done", {15'd0, d1}, 16'd1);
        cyc(4);
        check("zero_frozen_tick", {15'd0, tk1}, 16'd0);
        check("zero_frozen_done", {15'd0, d1}, 16'd1);

        do_load(16'h0000);
        check("load_zero_done", {15'd0, d1}, 16'd0);
        cyc(4);
        check("zero_start_done", {15'd0, d1}, 16'd1);
        check("zero_start_tick", {15'd0, tk1}, 16'd0);
        check("zero_start_time", t1, 16'h0000);
        do_load(16'h0005);
        check("resume_done", {15'd0, d1}, 16'd0);
        cyc(4);
        check("resume_0004", t1, 16'h0004);

        do_load(16'h0030);
        cyc(3);
        count_enabled = 1'b0;
        cyc(10);
        check("pause_hold", t1, 16'h0030);
        check("pause_tick", {15'd0, tk1}, 16'd0);
        count_enabled = 1'b1;
        lap_capture = 1'b1;
        cyc(1);
        lap_capture = 1'b0;
        check("resume_step", t1, 16'h0029);
        check("resume_tick", {15'd0, tk1}, 16'd1);
        check("lap_prestep", l1, 16'h0030);
        lap_capture = 1'b1;
        do_load(16'h1234);
        lap_capture = 1'b0;
        check("lap_preload", l1, 16'h0029);
        check("load_1234", t1, 16'h1234);

        do_load(16'h7A9F);
        check("clamp_wrap", t1, 16'h5959);
        check("clamp_sat", t0, 16'h5959);
        do_load(16'h5A23);
        check("clamp_min_ones", t1, 16'h5923);
        count_down = 1'b0;
        do_load(16'h0100);
        cyc(3);
        do_load(16'h0200);
        check("load_step_time", t1, 16'h0200);
        check("load_step_tick", {15'd0, tk1}, 16'd0);
        cyc(3);
        check("after_load_hold", t1, 16'h0200);
        cyc(1);
        check("after_load_step", t1, 16'h0201);

        init_regs = 1'b1;
        cyc(1);
        init_regs = 1'b0;
        check("init_time", t1, 16'h0000);
        check("init_lap", l1, 16'h0000);
        check("init_tick", {15'd0, tk1}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
